// File: rtl/ifetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_ctrl_if
//  Description : Bus bundle between the fetch sequencer, the instruction ROM
//                and the IF/ID stage.
//                  cs_rom   - ROM chip-select
//                  pc_addr  - ROM byte address
//                  i_in     - ROM read data, combinational from pc_addr
//                  if_valid - head of the prefetch FIFO is valid
//                  if_instr - head instruction
//                  if_pc    - head instruction address
//                  id_ready - decode accepts the head on this edge
//                Modports: master = fetch sequencer, slave = ROM/decode side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_ctrl_if #(
    parameter int INSTR_WIDTH = 32
);
    logic                   cs_rom;
    logic [INSTR_WIDTH-1:0] pc_addr;
    logic [INSTR_WIDTH-1:0] i_in;
    logic                   if_valid;
    logic [INSTR_WIDTH-1:0] if_instr;
    logic [INSTR_WIDTH-1:0] if_pc;
    logic                   id_ready;

    modport master (
        output cs_rom, pc_addr, if_valid, if_instr, if_pc,
        input  i_in, id_ready
    );

    modport slave (
        input  cs_rom, pc_addr, if_valid, if_instr, if_pc,
        output i_in, id_ready
    );
endinterface
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_ctrl
//  Description : Instruction-fetch sequencer. Owns the fetch PC, drives the
//                combinational instruction ROM, buffers returned words in a
//                first-word-fall-through prefetch FIFO and presents
//                {pc, instr} to IF/ID with a valid/ready handshake.
//                Redirects flush the FIFO and restart fetch at the target.
//  Ports       : clk, rst_n (async, active low)
//                fetch_en        - fetch enable (queued entries still drain)
//                redirect_valid  - branch/jump taken this cycle
//                redirect_pc     - redirect target byte address
//                bus (master)    - ROM and IF/ID signals, see ifetch_ctrl_if
//                fifo_count      - occupied prefetch entries
//                addr_fault      - sticky out-of-range fetch flag
//  Options     : IFETCH_RANGE_CHECK_EN - stop fetching past ROM_DEPTH and
//                enter the FAULT state; when undefined addr_fault is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_ctrl #(
    parameter int                     INSTR_WIDTH = 32,
    parameter int                     FIFO_DEPTH  = 4,
    parameter logic [INSTR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                     ROM_DEPTH   = 256
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    input  wire logic                         fetch_en,
    input  wire logic                         redirect_valid,
    input  wire logic [INSTR_WIDTH-1:0]       redirect_pc,
    ifetch_ctrl_if.master                     bus,
    output logic      [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                              addr_fault
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;
`ifdef IFETCH_RANGE_CHECK_EN
    localparam logic [1:0] c_ST_FAULT = 2'd3;
    localparam logic [INSTR_WIDTH-1:0] c_ROM_LAST = INSTR_WIDTH'(ROM_DEPTH - 4);
`endif

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [INSTR_WIDTH-1:0] r_fetch_pc;
    logic [c_AW-1:0]        r_wr_ptr;
    logic [c_AW-1:0]        r_rd_ptr;
    logic [c_CW-1:0]        r_count;
    logic [INSTR_WIDTH-1:0] r_mem_pc    [FIFO_DEPTH];
    logic [INSTR_WIDTH-1:0] r_mem_instr [FIFO_DEPTH];
    logic [INSTR_WIDTH-1:0] r_last_pc;
    logic [INSTR_WIDTH-1:0] r_last_instr;

    logic w_full;
    logic w_empty;
    logic w_fault_cond;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == c_CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);

`ifdef IFETCH_RANGE_CHECK_EN
    logic r_addr_fault;

    assign w_fault_cond = (r_fetch_pc > c_ROM_LAST);
    assign addr_fault   = r_addr_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_fault <= 1'b0;
        end else if (redirect_valid) begin
            r_addr_fault <= 1'b0;
        end else if ((r_state == c_ST_FETCH) && w_fault_cond) begin
            r_addr_fault <= 1'b1;
        end
    end
`else
    // The range compare has no consumer in this build.
    logic w_unused_range;

    assign w_unused_range = (r_fetch_pc > INSTR_WIDTH'(ROM_DEPTH - 4));
    assign w_fault_cond   = 1'b0;
    assign addr_fault     = 1'b0;
`endif

    // Redirect discards any push or pop on its edge; cs_rom already excludes it.
    assign w_push = bus.cs_rom;
    assign w_pop  = bus.if_valid && bus.id_ready && !redirect_valid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (redirect_valid) begin
            w_next_state = c_ST_FETCH;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (fetch_en) w_next_state = c_ST_FETCH;
                end
                c_ST_FETCH: begin
                    if (w_full || !fetch_en) w_next_state = c_ST_HOLD;
`ifdef IFETCH_RANGE_CHECK_EN
                    if (w_fault_cond) w_next_state = c_ST_FAULT;
`endif
                end
                c_ST_HOLD: begin
                    if (!w_full && fetch_en) w_next_state = c_ST_FETCH;
                end
`ifdef IFETCH_RANGE_CHECK_EN
                c_ST_FAULT: begin
                    w_next_state = c_ST_FAULT;
                end
`endif
                default: begin
                    w_next_state = c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Head is presented combinationally; when the FIFO is
    // empty the last popped entry is shown so the outputs stay stable.
    // ------------------------------------------------------------------
    always_comb begin
        bus.cs_rom   = (r_state == c_ST_FETCH) && fetch_en && !w_full &&
                       !redirect_valid && !w_fault_cond;
        bus.pc_addr  = r_fetch_pc;
        bus.if_valid = !w_empty;
        bus.if_pc    = w_empty ? r_last_pc    : r_mem_pc[r_rd_ptr];
        bus.if_instr = w_empty ? r_last_instr : r_mem_instr[r_rd_ptr];
        fifo_count   = r_count;
    end

    // ------------------------------------------------------------------
    // Fetch PC, FIFO pointers/count and last-popped holding registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc   <= RESET_PC;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_last_pc    <= '0;
            r_last_instr <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[INSTR_WIDTH-1:2], 2'b00};
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + INSTR_WIDTH'(4);
                r_wr_ptr   <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + c_AW'(1);
                r_last_pc    <= r_mem_pc[r_rd_ptr];
                r_last_instr <= r_mem_instr[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
            r_mem_instr[r_wr_ptr] <= bus.i_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_ctrl
//  Description : Self-checking bench for ifetch_ctrl. A ROM model drives
//                i_in; a scoreboard queues {pc, instr} on every fetch and
//                compares against the head on every accepted pop. Directed
//                scenarios cover reset, streaming, back-pressure, redirects
//                (aligned, unaligned, with concurrent pop) and range check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_ctrl;

    localparam int c_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  fifo_count;
    logic        addr_fault;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t        q[$];
    logic [31:0] model_pc;
    logic [31:0] last_pop_pc;

    ifetch_ctrl_if #(.INSTR_WIDTH(32)) bus ();

    ifetch_ctrl #(
        .INSTR_WIDTH (32),
        .FIFO_DEPTH  (c_DEPTH),
        .RESET_PC    (32'h0000_0000),
        .ROM_DEPTH   (256)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .fifo_count     (fifo_count),
        .addr_fault     (addr_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2001_0008;
            32'h0000_0004: return 32'h3402_000c;
            32'h0000_0008: return 32'h0022_1820;
            32'h0000_0034: return 32'had02_000a;
            32'h0000_0038: return 32'h8d04_000a;
            default:       return 32'hc000_0000 ^ a;
        endcase
    endfunction

    always_comb bus.i_in = rom_word(bus.pc_addr);

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: compares every cycle, then advances the model to the
    // state the DUT reaches at the following rising edge.
    always @(negedge clk) begin
        logic pop;
        if (!rst_n) begin
            q.delete();
            model_pc    = 32'h0;
            last_pop_pc = 32'h0;
        end else begin
            chk_eq("sb_pc_addr", bus.pc_addr, model_pc);
            chk_eq("sb_count", fifo_count, q.size());
            chk_eq("sb_valid", bus.if_valid, q.size() != 0);
            if (bus.cs_rom)
                chk_eq("sb_cs_legal", {fetch_en, redirect_valid, q.size() < c_DEPTH}, 3'b101);
            pop = bus.if_valid && bus.id_ready && !redirect_valid && (q.size() > 0);
            if (pop)
                chk_eq("sb_head", {bus.if_pc, bus.if_instr}, q[0]);
            if (redirect_valid) begin
                q.delete();
                model_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (pop) begin
                    last_pop_pc = q[0].pc;
                    void'(q.pop_front());
                end
                if (bus.cs_rom) begin
                    q.push_back('{pc: model_pc, instr: rom_word(model_pc)});
                    model_pc = model_pc + 32'd4;
                end
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic fe, input logic rdy);
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        bus.id_ready   = 1'b0;
        @(negedge clk);
        drive_edge();
        rst_n        = 1'b1;
        fetch_en     = fe;
        bus.id_ready = rdy;
    endtask

    task automatic wait_count(input int n, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fifo_count == 3'(n)) break;
        end
        chk_eq(tag, fifo_count, n);
    endtask

    task automatic wait_cs(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.cs_rom) break;
        end
        chk_eq(tag, bus.cs_rom, 1);
    endtask

    task automatic wait_valid_low(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.if_valid) break;
        end
        chk_eq(tag, bus.if_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        bus.id_ready   = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk_eq("rst_count", fifo_count, 0);
        chk_eq("rst_valid", bus.if_valid, 0);
        chk_eq("rst_instr", bus.if_instr, 0);
        chk_eq("rst_pc", bus.if_pc, 0);
        chk_eq("rst_cs", bus.cs_rom, 0);
        chk_eq("rst_addr", bus.pc_addr, 0);
        chk_eq("rst_fault", addr_fault, 0);

        // Streaming from reset
        drive_edge();
        rst_n = 1'b1; fetch_en = 1'b1; bus.id_ready = 1'b1;
        wait_cs(4, "s1_first_cs");
        chk_eq("s1_addr0", bus.pc_addr, 32'h0);
        @(negedge clk);
        chk_eq("s1_valid", bus.if_valid, 1);
        chk_eq("s1_pc0", bus.if_pc, 32'h0);
        chk_eq("s1_i0", bus.if_instr, 32'h2001_0008);
        @(negedge clk);
        chk_eq("s1_pc4", bus.if_pc, 32'h4);
        chk_eq("s1_i4", bus.if_instr, 32'h3402_000c);
        @(negedge clk);
        chk_eq("s1_pc8", bus.if_pc, 32'h8);
        chk_eq("s1_i8", bus.if_instr, 32'h0022_1820);

        // fetch_en low: queue drains, outputs hold the last popped entry
        drive_edge();
        fetch_en = 1'b0;
        wait_valid_low(8, "s1_drain");
        chk_eq("s1_hold_last", bus.if_pc, last_pop_pc);
        @(negedge clk);
        chk_eq("s1_no_fetch", bus.cs_rom, 0);

        // Back-pressure from reset: exactly four fetches, then resume
        do_reset(1'b1, 1'b0);
        wait_count(4, 10, "s2_fill");
        chk_eq("s2_cs_full", bus.cs_rom, 0);
        @(negedge clk);
        chk_eq("s2_still4", fifo_count, 4);
        chk_eq("s2_head0", bus.if_pc, 32'h0);
        drive_edge();
        bus.id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_eq("s2_nogap", bus.if_valid, 1);
            if (i == 4) chk_eq("s2_resume", bus.if_pc, 32'h10);
        end

        // Redirect with three entries queued
        do_reset(1'b1, 1'b0);
        wait_count(2, 10, "s3_fill2");
        drive_edge();
        redirect_valid = 1'b1; redirect_pc = 32'h34;
        @(negedge clk);
        chk_eq("s3_pre3", fifo_count, 3);
        chk_eq("s3_cs_redir", bus.cs_rom, 0);
        drive_edge();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk_eq("s3_flush", fifo_count, 0);
        chk_eq("s3_valid0", bus.if_valid, 0);
        chk_eq("s3_addr", bus.pc_addr, 32'h34);
        chk_eq("s3_cs", bus.cs_rom, 1);
        @(negedge clk);
        chk_eq("s3_valid1", bus.if_valid, 1);
        chk_eq("s3_pc", bus.if_pc, 32'h34);
        chk_eq("s3_instr", bus.if_instr, 32'had02_000a);

        // Unaligned redirect target
        drive_edge();
        redirect_valid = 1'b1; redirect_pc = 32'h3a;
        drive_edge();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk_eq("s4_align", bus.pc_addr, 32'h38);
        @(negedge clk);
        chk_eq("s4_pc", bus.if_pc, 32'h38);
        chk_eq("s4_instr", bus.if_instr, 32'h8d04_000a);

        // Redirect coinciding with a pop on a full FIFO
        wait_count(4, 10, "s5_full");
        drive_edge();
        redirect_valid = 1'b1; redirect_pc = 32'h80; bus.id_ready = 1'b1;
        @(negedge clk);
        chk_eq("s5_pre_full", fifo_count, 4);
        drive_edge();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk_eq("s5_flush", fifo_count, 0);
        chk_eq("s5_valid0", bus.if_valid, 0);
        chk_eq("s5_hold_last", bus.if_pc, last_pop_pc);
        @(negedge clk);
        chk_eq("s5_head80", bus.if_pc, 32'h80);
        @(negedge clk);
        chk_eq("s5_head84", bus.if_pc, 32'h84);

        // ROM range boundary
        drive_edge();
        redirect_valid = 1'b1; redirect_pc = 32'hfc;
        drive_edge();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk_eq("s6_cs_fc", bus.cs_rom, 1);
        chk_eq("s6_addr_fc", bus.pc_addr, 32'hfc);
        @(negedge clk);
        chk_eq("s6_addr_100", bus.pc_addr, 32'h100);
`ifdef IFETCH_RANGE_CHECK_EN
        chk_eq("s6_cs_100", bus.cs_rom, 0);
        @(negedge clk);
        chk_eq("s6_fault", addr_fault, 1);
        chk_eq("s6_cs_fault", bus.cs_rom, 0);
`else
        chk_eq("s6_cs_100", bus.cs_rom, 1);
        @(negedge clk);
        chk_eq("s6_fault", addr_fault, 0);
        chk_eq("s6_cs_104", bus.cs_rom, 1);
`endif
        drive_edge();
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        drive_edge();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk_eq("s6_fault_clr", addr_fault, 0);
        chk_eq("s6_cs_resume", bus.cs_rom, 1);
        chk_eq("s6_addr_resume", bus.pc_addr, 32'h0);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch sequencer for the byte-addressed, combinationally-read instruction ROM (little-endian 4-byte words, `cs_rom`/`pc_addr` → `i_out`).
- Owns the fetch PC and drives the ROM's chip-select and address.
- Captures returned words into a small first-word-fall-through prefetch FIFO.
- Hands `{pc, instr}` to the IF/ID stage with a valid/ready handshake. Branch/jump redirects flush the FIFO and restart fetch.

Parameters:
- INSTR_WIDTH, 32, instruction and PC width
- FIFO_DEPTH, 4, prefetch entries (power of 2, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- ROM_DEPTH, 256, ROM size in bytes (used only by range check)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  global fetch enable (0 = halt fetching; drain continues)
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  INSTR_WIDTH  target byte address
- cs_rom  out  1  ROM chip-select, combinational
- pc_addr  out  INSTR_WIDTH  ROM byte address (= fetch_pc)
- i_in  in  INSTR_WIDTH  ROM read data, valid same cycle as cs_rom
- if_valid  out  1  FIFO head valid
- if_instr  out  INSTR_WIDTH  head instruction
- if_pc  out  INSTR_WIDTH  head instruction address
- id_ready  in  1  decode accepts head this edge
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
- addr_fault  out  1  fetch address out of ROM range (sticky)

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC, FIFO empty, fifo_count=0, if_valid=0.
  - if_instr=0, if_pc=0, addr_fault=0, state=IDLE, cs_rom=0.
- States:
  - IDLE: leaves for FETCH when fetch_en=1.
  - FETCH: issues fetches.
  - HOLD: entered when FIFO full or fetch_en=0; returns to FETCH when neither holds.
  - FAULT: only with macro.
  - redirect_valid forces FETCH from IDLE/HOLD/FAULT.
- Fetch issue:
  - cs_rom = (state==FETCH) & fetch_en & !full & !redirect_valid & !fault_cond.
  - pc_addr = fetch_pc at all times.
- Push: at an edge where cs_rom=1, {fetch_pc, i_in} is written to the FIFO tail and fetch_pc += 4 (mod 2^32, natural wrap).
- Pop: at an edge where if_valid & id_ready, the head is removed.
- Simultaneous push/pop:
  - Allowed when not full; count unchanged.
  - When full, push is blocked even if a pop occurs that edge; cs_rom depends on `full`, not on id_ready.
- Output: if_instr/if_pc reflect the head combinationally (FWFT). They hold the last popped value when empty; if_valid=0 then.
- Latency: fetch at edge N → if_valid=1 after edge N (visible in cycle N+1). Throughput is 1 instr/cycle when id_ready stays high.
- Redirect (highest priority) at edge N:
  - FIFO flushed, count=0; any push and pop that edge are discarded.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}; unaligned targets are force-aligned.
  - if_valid=0 in cycle N+1. Target fetched in cycle N+1, presented in cycle N+2.
  - Clears addr_fault.
- fetch_en=0: no new fetches; existing entries still drain; fetch_pc held.
- Back-to-back redirects: the last one wins. Each flushes; no fetch occurs while redirect_valid=1.
- Reset mid-operation: immediate return to reset values, regardless of outstanding FIFO contents.

Optional Feature:
- Macro: IFETCH_RANGE_CHECK_EN.
- With it defined:
  - fault_cond = (fetch_pc > ROM_DEPTH-4).
  - On fault_cond in FETCH: no fetch, state → FAULT, addr_fault=1 sticky.
  - Entries already in the FIFO still drain.
  - Exit FAULT only by redirect to an in-range PC or by reset.
- Without it:
  - fault_cond=0, addr_fault tied 0, FAULT state absent.
  - Fetches issue at any address; ROM contents are returned as-is.

Test Plan:
- Reset release, fetch_en=1, id_ready=1 → cs_rom=1, pc_addr=0; cycle 2: if_valid=1, if_pc=0, if_instr=32'h2001_0008; next: if_pc=4, if_instr=32'h3402_000c; then 8, 32'h0022_1820.
- id_ready=0 from start → exactly 4 pushes (pc 0,4,8,c), fifo_count=4, cs_rom=0, state HOLD; raise id_ready → pops 0,4,8,c in order, fetch resumes at 32'h10 with no gap >1 cycle.
- Redirect_valid=1, redirect_pc=32'h34 while FIFO holds 3 entries → next cycle fifo_count=0, if_valid=0, pc_addr=32'h34; following cycle if_pc=32'h34, if_instr=32'had02_000a.
- redirect_pc=32'h3a (unaligned) → pc_addr=32'h38, first instr 32'h8d04_000a.
- Redirect and pop on same edge with full FIFO → popped entry not re-presented, count=0, no duplicate.
- With IFETCH_RANGE_CHECK_EN, redirect to 32'hfc then run → fetch 32'hfc, then pc 32'h100 raises addr_fault, cs_rom=0; redirect to 0 clears fault and resumes. Without the macro → fetch at 32'h100 issues, addr_fault=0.
